light_mode_ctrl: RTL and testbench

LIGHT_MODE_CTRL -- requirements
Module: light_mode_ctrl

---
 rtl/light_mode_ctrl.sv | 126 ++++++++++++
 tb/tb_light_mode_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/light_mode_ctrl.sv
// Lamp mode controller: manual on/off plus an occupancy/darkness driven auto
// mode with a hold-off timer. The brightness ramps toward the requested target
// one step per prescaler tick and drives a free-running 8-bit PWM.
module light_mode_ctrl #(
  parameter int HOLD_T   = 10000,
  parameter int RAMP_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_pulse,
  input  logic       b_pulse,
  input  logic       presence,
  input  logic       dark,
  output logic       lamp_pwm,
  output logic [7:0] level,
  output logic       auto_mode,
  output logic       lamp_req
);

  localparam int HW = $clog2(HOLD_T) + 1;
  localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_T - 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(RAMP_DIV - 1);

  typedef enum logic [2:0] {
    MAN_OFF,
    MAN_ON,
    AUTO_WAIT,
    AUTO_ON,
    AUTO_HOLD
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_cnt_nxt;
  logic [PW-1:0] presc;
  logic          tick;
  logic [7:0]    pwm_cnt;

  // One brightness step toward the target, pinned at both ends of the range.
  function automatic logic [7:0] step_level(input logic [7:0] cur, input logic up);
    if (up) begin
      return (cur == 8'hFF) ? cur : cur + 8'd1;
    end else begin
      return (cur == 8'h00) ? cur : cur - 8'd1;
    end
  endfunction

  // Next-state and hold-timer decode; a_pulse outranks b_pulse everywhere.
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    case (state)
      MAN_OFF: begin
        if (a_pulse)      state_nxt = AUTO_WAIT;
        else if (b_pulse) state_nxt = MAN_ON;
      end
      MAN_ON: begin
        if (a_pulse)      state_nxt = AUTO_WAIT;
        else if (b_pulse) state_nxt = MAN_OFF;
      end
      AUTO_WAIT: begin
        if (a_pulse)                state_nxt = MAN_OFF;
        else if (presence && dark)  state_nxt = AUTO_ON;
      end
      AUTO_ON: begin
        if (a_pulse) begin
          state_nxt = MAN_OFF;
        end else if (!presence) begin
          state_nxt    = AUTO_HOLD;
          hold_cnt_nxt = '0;
        end
      end
      AUTO_HOLD: begin
        if (a_pulse)                    state_nxt = MAN_OFF;
        else if (presence)              state_nxt = AUTO_ON;
        else if (hold_cnt == HOLD_LAST) state_nxt = AUTO_WAIT;
        else                            hold_cnt_nxt = hold_cnt + 1'b1;
      end
      default: state_nxt = MAN_OFF;
    endcase
  end

  // State, hold timer and the registered mode outputs decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= MAN_OFF;
      hold_cnt  <= '0;
      auto_mode <= 1'b0;
      lamp_req  <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_cnt_nxt;
      auto_mode <= (state_nxt == AUTO_WAIT) || (state_nxt == AUTO_ON) ||
                   (state_nxt == AUTO_HOLD);
      lamp_req  <= (state_nxt == MAN_ON) || (state_nxt == AUTO_ON) ||
                   (state_nxt == AUTO_HOLD);
    end
  end

  assign tick = (presc == PRESC_LAST);

  // Ramp prescaler and brightness level; level moves one step per tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      level <= 8'd0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) level <= step_level(level, lamp_req);
    end
  end

  // Free-running PWM counter and registered lamp drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt  <= 8'd0;
      lamp_pwm <= 1'b0;
    end else begin
      pwm_cnt  <= pwm_cnt + 8'd1;
      lamp_pwm <= (pwm_cnt < level);
    end
  end

endmodule

// File: tb/tb_light_mode_ctrl.sv
// Bench for light_mode_ctrl: timed expectations are queued as stimulus is
// applied and compared against the outputs on the cycle they fall due.
module tb_light_mode_ctrl;

  localparam int HOLD_T   = 20;
  localparam int RAMP_DIV = 4;

  localparam int S_LVL  = 0;
  localparam int S_REQ  = 1;
  localparam int S_AUTO = 2;
  localparam int S_PWM  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_pulse;
  logic       b_pulse;
  logic       presence;
  logic       dark;
  logic       lamp_pwm;
  logic [7:0] level;
  logic       auto_mode;
  logic       lamp_req;

  typedef struct {
    int    cyc;
    int    sel;
    int    exp;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   rel;
  int   n_chk;
  int   n_pass;

  always #5 clk = ~clk;

  light_mode_ctrl #(.HOLD_T(HOLD_T), .RAMP_DIV(RAMP_DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .a_pulse  (a_pulse),
    .b_pulse  (b_pulse),
    .presence (presence),
    .dark     (dark),
    .lamp_pwm (lamp_pwm),
    .level    (level),
    .auto_mode(auto_mode),
    .lamp_req (lamp_req)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic logic [31:0] get_out(input int sel);
    case (sel)
      S_LVL:   return {24'd0, level};
      S_REQ:   return {31'd0, lamp_req};
      S_AUTO:  return {31'd0, auto_mode};
      S_PWM:   return {31'd0, lamp_pwm};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push(input int c, input int sel, input int e, input string tag);
    exp_t x;
    x.cyc = c;
    x.sel = sel;
    x.exp = e;
    x.tag = tag;
    sb.push_back(x);
  endtask

  task automatic drain(input int c);
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == c) begin
        check(sb[i].tag, get_out(sb[i].sel), sb[i].exp);
        sb.delete(i);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    drain(cyc);
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  // First ramp tick strictly after edge e, counting edges from reset release.
  function automatic int next_tick(input int e);
    return rel + ((e - rel) / RAMP_DIV + 1) * RAMP_DIV;
  endfunction

  // Queue the level milestones of a full 0<->255 ramp whose target flips at edge e.
  task automatic ramp_exp(input int e, input bit up, input string tg);
    int t;
    t = next_tick(e);
    push(t - 1, S_LVL, up ? 0 : 255, {tg, "_before_tick"});
    push(t, S_LVL, up ? 1 : 254, {tg, "_first_step"});
    push(t + 253 * RAMP_DIV, S_LVL, up ? 254 : 1, {tg, "_near_end"});
    push(t + 254 * RAMP_DIV, S_LVL, up ? 255 : 0, {tg, "_end"});
    push(t + 254 * RAMP_DIV + 60, S_LVL, up ? 255 : 0, {tg, "_saturated"});
  endtask

  task automatic reset_now_exp(input string tg);
    push(-1, S_LVL, 0, {tg, "_level"});
    push(-1, S_PWM, 0, {tg, "_pwm"});
    push(-1, S_REQ, 0, {tg, "_req"});
    push(-1, S_AUTO, 0, {tg, "_auto"});
    drain(-1);
  endtask

  initial begin
    int e;
    int t;
    int r;
    int s;
    int cnt;
    n_chk = 0; n_pass = 0; cyc = 0; rel = 0;
    rst = 1'b1; a_pulse = 1'b0; b_pulse = 1'b0; presence = 1'b0; dark = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_now_exp("reset");
    rst = 1'b0;
    rel = cyc;

    // Manual ramp up: b_pulse sampled at edge 10.
    push(9, S_REQ, 0, "man_idle_req");
    run_to(9);
    b_pulse = 1'b1;
    e = cyc + 1;
    push(e, S_REQ, 1, "man_on_req");
    push(e, S_AUTO, 0, "man_on_auto");
    ramp_exp(e, 1'b1, "ramp_up");
    step();
    b_pulse = 1'b0;
    t = next_tick(e) + 254 * RAMP_DIV;
    run_to(t + 2);
    cnt = 0;
    repeat (256) begin
      step();
      cnt += int'(lamp_pwm);
    end
    check("pwm_full_duty", cnt, 255);
    run_to(t + 300);

    // Manual ramp down.
    b_pulse = 1'b1;
    e = cyc + 1;
    push(e, S_REQ, 0, "man_off_req");
    ramp_exp(e, 1'b0, "ramp_down");
    step();
    b_pulse = 1'b0;
    t = next_tick(e) + 254 * RAMP_DIV;
    run_to(t + 2);
    cnt = 0;
    repeat (256) begin
      step();
      cnt += int'(lamp_pwm);
    end
    check("pwm_zero_duty", cnt, 0);
    run_to(t + 300);

    // Auto mode entry and dark gate.
    a_pulse = 1'b1;
    e = cyc + 1;
    push(e, S_AUTO, 1, "auto_enter");
    push(e, S_REQ, 0, "auto_enter_req");
    step();
    a_pulse = 1'b0;
    presence = 1'b1;
    dark = 1'b0;
    for (int i = 1; i <= 10; i++) push(cyc + i, S_REQ, 0, "dark_gate_req");
    repeat (10) step();
    dark = 1'b1;
    push(cyc + 1, S_REQ, 1, "dark_on_req");
    push(cyc + 1, S_AUTO, 1, "dark_on_auto");
    repeat (5) step();

    // Hold timeout; dark dropping must not shorten it.
    presence = 1'b0;
    dark = 1'b0;
    e = cyc + 1;
    for (int i = 0; i < HOLD_T; i++) push(e + i, S_REQ, 1, "hold_keep");
    push(e + HOLD_T, S_REQ, 0, "hold_expire");
    push(e + HOLD_T, S_AUTO, 1, "hold_to_wait_auto");
    run_to(e + HOLD_T);
    presence = 1'b1;
    dark = 1'b1;
    push(cyc + 1, S_REQ, 1, "wait_retrig_req");
    step();

    // Hold re-trigger when hold_cnt reaches 10, then a full hold again.
    presence = 1'b0;
    r = cyc + 1;
    for (int i = 0; i < 26; i++) push(r + i, S_REQ, 1, "retrig_keep");
    run_to(r + 10);
    presence = 1'b1;
    run_to(r + 15);
    presence = 1'b0;
    s = cyc + 1;
    for (int i = 0; i < HOLD_T; i++) push(s + i, S_REQ, 1, "rehold_keep");
    push(s + HOLD_T, S_REQ, 0, "rehold_expire");
    run_to(s + HOLD_T);
    dark = 1'b0;

    // b_pulse ignored in auto; a_pulse back to manual; priority of a over b.
    b_pulse = 1'b1;
    push(cyc + 1, S_AUTO, 1, "b_in_auto_mode");
    push(cyc + 1, S_REQ, 0, "b_in_auto_req");
    step();
    b_pulse = 1'b0;
    a_pulse = 1'b1;
    push(cyc + 1, S_AUTO, 0, "auto_exit_mode");
    step();
    a_pulse = 1'b0;
    b_pulse = 1'b1;
    push(cyc + 1, S_REQ, 1, "prio_setup_on");
    step();
    b_pulse = 1'b0;
    step();
    a_pulse = 1'b1;
    b_pulse = 1'b1;
    push(cyc + 1, S_AUTO, 1, "prio_auto");
    push(cyc + 1, S_REQ, 0, "prio_req");
    push(cyc + 3, S_AUTO, 1, "prio_stay_auto");
    push(cyc + 3, S_REQ, 0, "prio_stay_req");
    step();
    a_pulse = 1'b0;
    b_pulse = 1'b0;
    repeat (3) step();

    // Clean restart, ramp to 100, then reset mid-ramp.
    rst = 1'b1;
    #1;
    reset_now_exp("rst_clean");
    repeat (2) step();
    rst = 1'b0;
    rel = cyc;
    b_pulse = 1'b1;
    e = cyc + 1;
    push(e, S_REQ, 1, "rst_test_on");
    t = next_tick(e) + 99 * RAMP_DIV;
    push(t, S_LVL, 100, "pre_rst_level");
    step();
    b_pulse = 1'b0;
    run_to(t);
    rst = 1'b1;
    #1;
    reset_now_exp("mid_ramp_rst");
    repeat (2) step();
    rst = 1'b0;
    rel = cyc;
    for (int i = 10; i <= 40; i += 10) begin
      push(cyc + i, S_LVL, 0, "post_rst_level");
      push(cyc + i, S_REQ, 0, "post_rst_req");
      push(cyc + i, S_AUTO, 0, "post_rst_auto");
    end
    repeat (40) step();

    check("sb_leftover", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
